// File: rtl/sdf_bf_stage.sv
// sdf_bf_stage: radix-2 single-path delay-feedback (DIF) butterfly stage.
//
// Phase A (first half of each 2*DEPTH-sample frame): incoming samples fill the
// delay line. The word leaving the head is emitted as a difference output
// (out_diff = 1). That word is the previous frame's recirculated difference.
// Phase B (second half): each input is paired with the head word. The scaled
// sum is emitted (out_diff = 0), and the scaled difference is written back
// into the tail.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  sample accepted this cycle; the stage advances only when high
//   in_re/im  input sample, WIDTH-bit two's complement components
//   out_valid one-cycle pulse per produced output (registered)
//   out_re/im output sample; holds its value while out_valid is low
//   out_diff  0 = sum branch, 1 = difference branch (needs twiddle)
//   out_idx   butterfly index n within the half-frame
module sdf_bf_stage #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDXW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             out_diff,
  output logic [IDXW-1:0]  out_idx
);

  localparam int unsigned CntW = $clog2(2 * DEPTH);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] dly_re_q [DEPTH];
  logic [WIDTH-1:0] dly_im_q [DEPTH];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_re_q, out_re_d;
  logic [WIDTH-1:0] out_im_q, out_im_d;
  logic             out_diff_q, out_diff_d;
  logic [IDXW-1:0]  out_idx_q, out_idx_d;

  logic             phase;
  logic [IDXW-1:0]  n;
  logic [WIDTH-1:0] head_re, head_im;
  logic [WIDTH-1:0] tail_re, tail_im;

  assign phase   = cnt_q[CntW-1];
  assign head_re = dly_re_q[0];
  assign head_im = dly_im_q[0];

  generate
    if (DEPTH > 1) begin : g_idx
      assign n = cnt_q[CntW-2:0];
    end else begin : g_idx_tied
      assign n = '0;
    end
  endgenerate

  // One extra bit of headroom; dropping the LSB is the arithmetic >>> 1,
  // which floors, and the result always fits back into WIDTH bits.
  logic signed [WIDTH:0] sum_re, sum_im, dif_re, dif_im;
  assign sum_re = $signed({head_re[WIDTH-1], head_re}) + $signed({in_re[WIDTH-1], in_re});
  assign sum_im = $signed({head_im[WIDTH-1], head_im}) + $signed({in_im[WIDTH-1], in_im});
  assign dif_re = $signed({head_re[WIDTH-1], head_re}) - $signed({in_re[WIDTH-1], in_re});
  assign dif_im = $signed({head_im[WIDTH-1], head_im}) - $signed({in_im[WIDTH-1], in_im});

  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    tail_re     = in_re;
    tail_im     = in_im;
    out_valid_d = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_diff_d  = out_diff_q;
    out_idx_d   = out_idx_q;
    if (in_valid) begin
      cnt_d = cnt_q + CntW'(1);
      if (!phase) begin
        // Head holds last frame's difference; there is none before priming.
        out_valid_d = primed_q;
        if (primed_q) begin
          out_re_d   = head_re;
          out_im_d   = head_im;
          out_diff_d = 1'b1;
          out_idx_d  = n;
        end
      end else begin
        tail_re     = dif_re[WIDTH:1];
        tail_im     = dif_im[WIDTH:1];
        out_valid_d = 1'b1;
        out_re_d    = sum_re[WIDTH:1];
        out_im_d    = sum_im[WIDTH:1];
        out_diff_d  = 1'b0;
        out_idx_d   = n;
        primed_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_diff_q  <= 1'b0;
      out_idx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dly_re_q[i] <= '0;
        dly_im_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_diff_q  <= out_diff_d;
      out_idx_q   <= out_idx_d;
      if (in_valid) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          dly_re_q[i] <= dly_re_q[i+1];
          dly_im_q[i] <= dly_im_q[i+1];
        end
        dly_re_q[DEPTH-1] <= tail_re;
        dly_im_q[DEPTH-1] <= tail_im;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_diff  = out_diff_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Bench for sdf_bf_stage: three instances (DEPTH = 32, 4, 1) share one input
// stream. A frame-level reference model gives the expected output of each
// instance after every cycle. Directed golden sequences cover the worked
// examples.
module tb_sdf_bf_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [16:0] in_re = '0;
  logic [16:0] in_im = '0;

  logic        ov32, ov4, ov1;
  logic [16:0] ore32, ore4, ore1, oim32, oim4, oim1;
  logic        odf32, odf4, odf1;
  logic [4:0]  oix32;
  logic [1:0]  oix4;
  logic [0:0]  oix1;

  always #5 clk = ~clk;

  sdf_bf_stage #(.WIDTH(17), .DEPTH(32), .IDXW(5)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(ov32), .out_re(ore32), .out_im(oim32), .out_diff(odf32), .out_idx(oix32));
  sdf_bf_stage #(.WIDTH(17), .DEPTH(4), .IDXW(2)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(ov4), .out_re(ore4), .out_im(oim4), .out_diff(odf4), .out_idx(oix4));
  sdf_bf_stage #(.WIDTH(17), .DEPTH(1), .IDXW(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(ov1), .out_re(ore1), .out_im(oim1), .out_diff(odf1), .out_idx(oix1));

  int n_chk = 0;
  int n_pass = 0;
  int pulses32 = 0;

  // Reference model state per instance (0: DEPTH 32, 1: DEPTH 4, 2: DEPTH 1).
  int dep [3] = '{32, 4, 1};
  int cur_re [3][64];
  int cur_im [3][64];
  int prv_re [3][64];
  int prv_im [3][64];
  int pos [3];
  bit primed [3];
  bit e_v [3];
  int e_re [3];
  int e_im [3];
  bit e_d [3];
  int e_idx [3];

  int lg4_re[$], lg4_df[$], lg4_ix[$];
  int lg1_re[$], lg1_df[$], lg1_ix[$];

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d: got %0d (0x%0h) want %0d (0x%0h)", tag, d, obs, obs, exp, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      pos[d] = 0; primed[d] = 1'b0; e_v[d] = 1'b0;
      e_re[d] = 0; e_im[d] = 0; e_d[d] = 1'b0; e_idx[d] = 0;
    end
  endtask

  // Frame view: x[n] and x[n+D] pair up. The sum is emitted when x[n+D]
  // arrives. The difference is emitted at position n of the following frame.
  task automatic model(input int d, input bit v, input int xr, input int xi);
    int dd, p;
    e_v[d] = 1'b0;
    if (!v) return;
    dd = dep[d];
    p  = pos[d];
    if (p < dd) begin
      if (primed[d]) begin
        e_v[d]   = 1'b1;
        e_re[d]  = (prv_re[d][p] - prv_re[d][p+dd]) >>> 1;
        e_im[d]  = (prv_im[d][p] - prv_im[d][p+dd]) >>> 1;
        e_d[d]   = 1'b1;
        e_idx[d] = p;
      end
    end else begin
      e_v[d]     = 1'b1;
      e_re[d]    = (cur_re[d][p-dd] + xr) >>> 1;
      e_im[d]    = (cur_im[d][p-dd] + xi) >>> 1;
      e_d[d]     = 1'b0;
      e_idx[d]   = p - dd;
      primed[d]  = 1'b1;
    end
    cur_re[d][p] = xr;
    cur_im[d][p] = xi;
    pos[d] = p + 1;
    if (pos[d] == 2 * dd) begin
      pos[d] = 0;
      for (int k = 0; k < 2 * dd; k++) begin
        prv_re[d][k] = cur_re[d][k];
        prv_im[d][k] = cur_im[d][k];
      end
    end
  endtask

  task automatic check_dut(input int d);
    logic        v, df;
    logic [16:0] r, i, er, ei;
    logic [31:0] ix;
    case (d)
      0: begin v = ov32; r = ore32; i = oim32; df = odf32; ix = {27'b0, oix32}; end
      1: begin v = ov4;  r = ore4;  i = oim4;  df = odf4;  ix = {30'b0, oix4};  end
      default: begin v = ov1; r = ore1; i = oim1; df = odf1; ix = {31'b0, oix1}; end
    endcase
    er = e_re[d][16:0];
    ei = e_im[d][16:0];
    chk("out_valid", d, {31'b0, v}, {31'b0, e_v[d]});
    chk("out_re", d, {15'b0, r}, {15'b0, er});
    chk("out_im", d, {15'b0, i}, {15'b0, ei});
    chk("out_diff", d, {31'b0, df}, {31'b0, e_d[d]});
    chk("out_idx", d, ix, e_idx[d]);
    if (v === 1'b1) begin
      if (d == 0) pulses32++;
      if (d == 1) begin
        lg4_re.push_back(int'($signed(r))); lg4_df.push_back(int'(df)); lg4_ix.push_back(int'(ix));
      end
      if (d == 2) begin
        lg1_re.push_back(int'($signed(r))); lg1_df.push_back(int'(df)); lg1_ix.push_back(int'(ix));
      end
    end
  endtask

  task automatic step(input bit v, input int xr, input int xi);
    in_valid = v;
    in_re    = xr[16:0];
    in_im    = xi[16:0];
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      model(d, v, int'($signed(xr[16:0])), int'($signed(xi[16:0])));
      check_dut(d);
    end
    in_valid = 1'b0;
  endtask

  // in_valid is held high during reset to exercise reset priority.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_re    = 17'h00123;
    in_im    = 17'h1fedc;
    @(posedge clk);
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) check_dut(d);
    rst      = 1'b0;
    in_valid = 1'b0;
    lg4_re.delete(); lg4_df.delete(); lg4_ix.delete();
    lg1_re.delete(); lg1_df.delete(); lg1_ix.delete();
  endtask

  task automatic gold4(input string tag, input int g_re[8], input int g_df[8],
                       input int g_ix[8]);
    chk({tag, "_count"}, 1, lg4_re.size(), 8);
    for (int k = 0; k < 8 && k < lg4_re.size(); k++) begin
      chk({tag, "_re"}, 1, lg4_re[k], g_re[k]);
      chk({tag, "_df"}, 1, lg4_df[k], g_df[k]);
      chk({tag, "_ix"}, 1, lg4_ix[k], g_ix[k]);
    end
  endtask

  task automatic feed_ramp(input bit stall);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, (k <= 8) ? k : 0, 0);
      if (stall && (k % 2 == 0)) repeat (3) step(1'b0, 777, -5);
    end
  endtask

  int g1_re[8] = '{3, 4, 5, 6, -2, -2, -2, -2};
  int g_df[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
  int g_ix[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int x3[12]   = '{65535, -65536, 65535, -3, 65535, -65536, -65536, 0, 0, 0, 0, 0};
  int g3_re[8] = '{65535, -65536, -1, -2, 0, 0, 65535, -2};
  int x6[5]    = '{4, 2, 10, 6, 0};
  int g6_re[4] = '{3, 1, 8, 2};
  int g6_df[4] = '{0, 1, 0, 1};

  initial begin
    model_reset();
    @(negedge clk);

    // Ramp 1..8 then 4 zeros, back to back.
    do_reset();
    feed_ramp(1'b0);
    gold4("ramp", g1_re, g_df, g_ix);

    // Same ramp with 3-cycle gaps after every 2nd sample.
    do_reset();
    feed_ramp(1'b1);
    gold4("stall", g1_re, g_df, g_ix);

    // Extreme values and floor rounding.
    do_reset();
    for (int k = 0; k < 12; k++) step(1'b1, x3[k], -x3[k] - 1);
    gold4("extreme", g3_re, g_df, g_ix);

    // Reset mid-frame discards everything in flight.
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 1000 + k, -1000 - k);
    do_reset();
    feed_ramp(1'b0);
    gold4("midrst", g1_re, g_df, g_ix);

    // Two random frames plus flush, with occasional gaps.
    do_reset();
    pulses32 = 0;
    for (int k = 0; k < 160; k++) begin
      if (($urandom % 5) == 0) step(1'b0, $urandom_range(0, 131071), 0);
      if (k < 128)
        step(1'b1, int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536);
      else
        step(1'b1, 0, 0);
    end
    chk("pulses32", 0, pulses32, 128);

    // DEPTH = 1 worked example.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, x6[k], 0);
    chk("d1_count", 2, lg1_re.size(), 4);
    for (int k = 0; k < 4 && k < lg1_re.size(); k++) begin
      chk("d1_re", 2, lg1_re[k], g6_re[k]);
      chk("d1_df", 2, lg1_df[k], g6_df[k]);
      chk("d1_ix", 2, lg1_ix[k], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdf_bf_stage.md
Name: sdf_bf_stage

Overview:
Radix-2 single-path delay-feedback (R2SDF, DIF) butterfly stage for the 64-point FFT datapath.
- Owns a DEPTH-word complex feedback delay line.
- Pairs each sample with the one DEPTH samples earlier and emits the scaled sum immediately; the scaled difference is recirculated through the delay line.
- Sits directly upstream of the twiddle-multiply/reorder stage, which consumes out_diff and out_idx to select the twiddle.
- A 64-point pipeline instantiates DEPTH = 32, 16, 8, 4, 2, 1.

Parameters:
WIDTH, 17, bits per real/imag component, two's complement
DEPTH, 32, delay-line length in complex words; power of two, >= 1
IDXW, 5, width of out_idx; must equal max(1, log2(DEPTH))

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input sample accepted this cycle; stage advances only when high
in_re  input  WIDTH  input real part
in_im  input  WIDTH  input imag part
out_valid  output  1  output sample valid
out_re  output  WIDTH  output real part
out_im  output  WIDTH  output imag part
out_diff  output  1  0 = sum branch, 1 = difference branch (needs twiddle)
out_idx  output  IDXW  butterfly index n within half-frame, 0..DEPTH-1

Behaviour:
- Reset (rst high at a clk edge):
  - cnt = 0, primed = 0, all delay-line words = 0.
  - out_valid = 0; out_re = out_im = 0; out_diff = 0; out_idx = 0.
  - rst has priority over in_valid. Asserting rst mid-frame discards all in-flight data; the first input after reset is x[0] of a new frame.
- cnt: log2(2*DEPTH)-bit counter, increments only on in_valid, wraps 2*DEPTH-1 -> 0. phase = cnt MSB; n = cnt low bits.
- Delay line: shift register; head = oldest word. It shifts exactly once per accepted input and holds when in_valid = 0.
- Phase A (phase = 0), on in_valid:
  - Tail is written with the input sample.
  - Head is emitted as a difference output: out_diff = 1, out_idx = n.
  - out_valid = primed.
- Phase B (phase = 1), on in_valid:
  - Each component computes s = (head + in) >>> 1 and d = (head - in) >>> 1.
  - Arithmetic is done at WIDTH+1 bits; the arithmetic right shift truncates toward -inf. Results always fit in WIDTH bits, so no saturation is needed.
  - s is emitted: out_diff = 0, out_idx = n, out_valid = 1.
  - d is written into the tail.
  - primed is set to 1 at the first phase-B acceptance after reset.
- Latency: outputs are registered, one cycle after the accepting edge. out_valid is a one-cycle pulse per accepted input once primed; it is 0 in cycles with no accepted input.
- Output data holds its last value when out_valid = 0.
- First-frame fill: the first DEPTH inputs after reset produce no valid output.
- Drain: frame f's differences emerge during frame f+1's phase A. The upstream block flushes the last frame by driving DEPTH further in_valid cycles (any data; zeros by convention).
- Stalls: arbitrary in_valid gaps do not alter the output value sequence, only its timing.
- DEPTH = 1: cnt is one bit and out_idx is tied to 0.
- No backpressure; downstream must accept every out_valid.

Test Plan:
1. DEPTH=4, reset, feed re = 1..8, im = 0, then 4 zeros, all consecutive.
   - No out_valid during the first 4 inputs.
   - Sums re = 3, 4, 5, 6 with out_diff = 0, idx 0..3.
   - Then differences re = -2, -2, -2, -2 with out_diff = 1, idx 0..3.
   - im = 0 throughout.
2. Same stimulus with in_valid dropped for 3 cycles after every 2nd sample -> identical value/flag/idx sequence; out_valid never high in a cycle following a non-accepted input.
3. DEPTH=4, WIDTH=17, extreme values:
   - head = 65535, in = 65535 -> sum 65535.
   - head = -65536, in = -65536 -> sum -65536.
   - head = 65535, in = -65536 -> diff 65535.
   - head = -3, in = 0 -> sum -2 (floor).
4. Reset mid-frame: feed 6 samples, assert rst 1 cycle, then feed the test-1 stimulus.
   - out_valid = 0 during the reset cycle and the following 4 inputs.
   - Output then exactly matches test 1; no leftover data appears.
5. DEPTH=32 default: two back-to-back random 64-sample frames plus 32-sample flush.
   - Every output matches the reference model (scaled sum/diff, correct out_idx and out_diff).
   - Exactly 128 out_valid pulses.
6. DEPTH=1: feed re = 4, 2, 10, 6, then 0.
   - Outputs: sum 3, diff 1, sum 8, diff 2.
   - out_idx = 0 throughout.
